// File: rtl/fifo_write_control.sv
// Write-side controller of a synchronous FIFO: handshake intake, write pointer, RAM write port, fill status.
// Latency: zero-cycle write of an accepted word when not full; a word accepted while full waits in a one-entry skid.
// Backpressure: o_ready_s drops only while the skid holds a word, so it never depends combinationally on full.
module fifo_write_control #(
  parameter int AW = 10,
  parameter int DW = 32
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_valid_s,
  input  logic [DW-1:0] i_data_s,
  output logic          o_ready_s,
  input  logic [AW-1:0] i_almostfull_lvl,
  input  logic [AW:0]   i_rptr,
  output logic [AW:0]   o_wptr,
  output logic [AW-1:0] o_waddr,
  output logic [DW-1:0] o_wdata,
  output logic          o_wen,
  output logic          o_full,
  output logic          o_almostfull,
  output logic [AW:0]   o_count,
  output logic          o_pending,
  input  logic          i_clr_hwm,
  output logic [AW:0]   o_hwm
);

  localparam logic [AW:0] DEPTH = {1'b1, {AW{1'b0}}};

  logic [AW:0]   wptr_q, wptr_d;
  logic          skid_vld_q, skid_vld_d;
  logic [DW-1:0] skid_dat_q, skid_dat_d;
  logic [AW:0]   hwm_q, hwm_d;

  logic [AW:0]   count;
  logic [AW:0]   free;
  logic          full;
  logic          accept;
  logic          wen;

  // Fill status from the pointer pair; the wrap bit separates full from empty.
  always_comb begin
    count = wptr_q - i_rptr;
    full  = (wptr_q[AW] != i_rptr[AW]) && (wptr_q[AW-1:0] == i_rptr[AW-1:0]);
    free  = DEPTH - count;
  end

  // Handshake and RAM write port; the skid word always goes first so order is kept.
  // The write port is held off during reset so a producer holding valid cannot write while the pointer is pinned.
  always_comb begin
    accept = i_valid_s & ~skid_vld_q;
    wen    = i_rst_n & ~full & (skid_vld_q | i_valid_s);
  end

  // Next-state for pointer, skid register and high-water mark.
  always_comb begin
    wptr_d     = wptr_q + {{AW{1'b0}}, wen};
    skid_vld_d = skid_vld_q;
    skid_dat_d = skid_dat_q;
    if (skid_vld_q) begin
      if (!full) skid_vld_d = 1'b0;
    end else if (accept && full) begin
      skid_vld_d = 1'b1;
      skid_dat_d = i_data_s;
    end
    if (i_clr_hwm)          hwm_d = '0;
    else if (count > hwm_q) hwm_d = count;
    else                    hwm_d = hwm_q;
  end

  // State registers; reset drops any word held in the skid.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wptr_q     <= '0;
      skid_vld_q <= 1'b0;
      skid_dat_q <= '0;
      hwm_q      <= '0;
    end else begin
      wptr_q     <= wptr_d;
      skid_vld_q <= skid_vld_d;
      skid_dat_q <= skid_dat_d;
      hwm_q      <= hwm_d;
    end
  end

  // Output mapping.
  always_comb begin
    o_ready_s    = ~skid_vld_q;
    o_pending    = skid_vld_q;
    o_wptr       = wptr_q;
    o_waddr      = wptr_q[AW-1:0];
    o_wdata      = skid_vld_q ? skid_dat_q : i_data_s;
    o_wen        = wen;
    o_full       = full;
    o_almostfull = (free <= {1'b0, i_almostfull_lvl});
    o_count      = count;
    o_hwm        = hwm_q;
  end

endmodule
